ram_burst_access: RTL and testbench

// - Parametrised successor to the single-word RAM wrapper. Holds an inferred single-port

---
 rtl/ram_burst_access_if.sv | 32 +++
 rtl/ram_burst_access.sv | 114 +++++++++++
 tb/tb_ram_burst_access.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_access_if.sv
// Burst RAM access bus: start/config, write handshake,
// read return and status.
interface ram_burst_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, base_addr, len,
    output wr_data, wr_valid,
    input  wr_ready, rd_data, rd_valid,
    input  busy, done
  );

  modport slave (
    input  start, mode, base_addr, len,
    input  wr_data, wr_valid,
    output wr_ready, rd_data, rd_valid,
    output busy, done
  );
endinterface

// File: rtl/ram_burst_access.sv
// Single-port synchronous RAM with a burst engine that
// streams len words to/from consecutive wrapping addresses.
module ram_burst_access #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  ram_burst_access_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   L_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, FINISH
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W:0]   remaining, remaining_n;
  logic [RD_LAT-1:0] vld_pipe, vld_pipe_n;
  logic              wr_fire, rd_issue, drain_ok;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // done trails the final rd_valid by exactly RD_LAT cycles
  assign drain_ok = (RD_LAT == 1) ? 1'b1 : (vld_pipe == '0);

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    wr_fire     = 1'b0;
    rd_issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          addr_n      = bus.base_addr;
          remaining_n = bus.len;
          if (bus.len == '0) state_n = FINISH;
          else if (bus.mode) state_n = WRITE;
          else               state_n = READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          wr_fire     = 1'b1;
          addr_n      = addr + A_ONE;
          remaining_n = remaining - L_ONE;
          if (remaining == L_ONE) state_n = FINISH;
        end
      end
      READ: begin
        rd_issue    = 1'b1;
        addr_n      = addr + A_ONE;
        remaining_n = remaining - L_ONE;
        if (remaining == L_ONE) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_ok) state_n = FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_n    = vld_pipe << 1;
    vld_pipe_n[0] = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      vld_pipe  <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      vld_pipe  <= vld_pipe_n;
    end
  end

  // RAM array is never reset; an aborting reset blocks the write
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[addr] <= bus.wr_data;
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst)           rd_data_q <= '0;
      else if (rd_issue) rd_data_q <= mem[addr];
    end
  end else begin : g_lat2
    logic [DATA_W-1:0] rd_raw;
    always_ff @(posedge clk) begin
      if (rd_issue) rd_raw <= mem[addr];
    end
    always_ff @(posedge clk) begin
      if (rst)              rd_data_q <= '0;
      else if (vld_pipe[0]) rd_data_q <= rd_raw;
    end
  end

  assign bus.wr_ready = (state == WRITE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FINISH);
  assign bus.rd_valid = vld_pipe[RD_LAT-1];
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_ram_burst_access.sv
// Directed bench for ram_burst_access: RD_LAT=1 and
// RD_LAT=2 instances driven with identical stimulus.
module tb_ram_burst_access;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_burst_access_if #(.DATA_W(32), .ADDR_W(10)) bus ();
  ram_burst_access_if #(.DATA_W(32), .ADDR_W(10)) bus2 ();

  assign bus2.start     = bus.start;
  assign bus2.mode      = bus.mode;
  assign bus2.base_addr = bus.base_addr;
  assign bus2.len       = bus.len;
  assign bus2.wr_data   = bus.wr_data;
  assign bus2.wr_valid  = bus.wr_valid;

  ram_burst_access #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ram_burst_access #(.DATA_W(32), .ADDR_W(10), .RD_LAT(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first1, last1, done1, dn1 = 0;
  int first2, last2, done2, dn2 = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (q1.size() == 0) first1 = cyc;
      q1.push_back(bus.rd_data);
      last1 = cyc;
    end
    if (bus2.rd_valid) begin
      if (q2.size() == 0) first2 = cyc;
      q2.push_back(bus2.rd_data);
      last2 = cyc;
    end
    if (bus.done) begin
      done1 = cyc;
      dn1++;
    end
    if (bus2.done) begin
      done2 = cyc;
      dn2++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus2.busy) && n < 200);
    check("idle", {31'b0, bus.busy | bus2.busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input logic [9:0] base, input int n,
                             input logic [31:0] d0,
                             input logic [7:0] vpat,
                             output int k);
    int idx = 0;
    logic acc;
    k = 0;
    bus.start = 1'b1; bus.mode = 1'b1;
    bus.base_addr = base; bus.len = 11'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (idx < n && k < 50) begin
      bus.wr_valid = vpat[k[2:0]];
      bus.wr_data  = d0 + 32'(idx);
      @(negedge clk);
      acc = bus.wr_ready && bus.wr_valid;
      @(posedge clk); #1;
      if (acc) idx++;
      k++;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [9:0] base, input int n,
                            output int st);
    q1.delete(); q2.delete();
    bus.start = 1'b1; bus.mode = 1'b0;
    bus.base_addr = base; bus.len = 11'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    st = cyc;
    wait_idle();
  endtask

  initial begin
    int k, st, db1, db2;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hA0; exp_a[1] = 32'hA1;
    exp_a[2] = 32'hA2; exp_a[3] = 32'hA3;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.base_addr = '0; bus.len = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
    check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_rd_data2", bus2.rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // write 0xA0..0xA3 at 0x010, wr_valid held high
    write_burst(10'h010, 4, 32'hA0, 8'hFF, k);
    @(negedge clk);
    check("wr4_done", {31'b0, bus.done}, 32'd1);
    check("wr4_cycles", 32'(k), 32'd4);
    wait_idle();

    read_burst(10'h010, 4, st);
    check("rd4_count", 32'(q1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd4_w%0d", i), q1[i], exp_a[i]);
      check($sformatf("rd4l2_w%0d", i), q2[i], exp_a[i]);
    end
    check("rd4_lat", 32'(first1 - st), 32'd1);
    check("rd4_donegap", 32'(done1 - last1), 32'd1);
    check("rd4l2_lat", 32'(first2 - st), 32'd2);
    check("rd4l2_donegap", 32'(done2 - last2), 32'd2);

    // stalled write: wr_valid 1,0,1,0,1
    write_burst(10'h020, 3, 32'hB0, 8'b0001_0101, k);
    @(negedge clk);
    check("stall_done", {31'b0, bus.done}, 32'd1);
    check("stall_cycles", 32'(k), 32'd5);
    wait_idle();
    read_burst(10'h020, 3, st);
    check("stall_count", 32'(q1.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("stall_w%0d", i), q1[i], 32'hB0 + 32'(i));

    // address wrap
    write_burst(10'h3FE, 3, 32'd1, 8'hFF, k);
    @(negedge clk);
    check("wrap_done", {31'b0, bus.done}, 32'd1);
    wait_idle();
    read_burst(10'h3FE, 3, st);
    check("wrap_count", 32'(q1.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("wrap_w%0d", i), q1[i], 32'(i + 1));
    read_burst(10'h000, 1, st);
    check("wrap_ram0", q1[0], 32'd3);

    // zero-length write burst at 0x010
    q1.delete(); q2.delete();
    bus.start = 1'b1; bus.mode = 1'b1;
    bus.base_addr = 10'h010; bus.len = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("zl_busy", {31'b0, bus.busy}, 32'd1);
    check("zl_done", {31'b0, bus.done}, 32'd1);
    check("zl_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
    @(negedge clk);
    check("zl_busy_end", {31'b0, bus.busy}, 32'd0);
    check("zl_done_end", {31'b0, bus.done}, 32'd0);
    check("zl_no_rd", 32'(q1.size()), 32'd0);
    @(posedge clk); #1;

    // second start during a len=8 read is ignored
    q1.delete(); q2.delete();
    db1 = dn1; db2 = dn2;
    bus.start = 1'b1; bus.mode = 1'b0;
    bus.base_addr = 10'h010; bus.len = 11'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.mode = 1'b1;
    bus.base_addr = 10'h020; bus.len = 11'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    check("ign_count", 32'(q1.size()), 32'd8);
    check("ign_count2", 32'(q2.size()), 32'd8);
    check("ign_done", 32'(dn1 - db1), 32'd1);
    check("ign_done2", 32'(dn2 - db2), 32'd1);

    // reset after 3 reads issued
    q1.delete(); q2.delete();
    db1 = dn1; db2 = dn2;
    bus.start = 1'b1; bus.mode = 1'b0;
    bus.base_addr = 10'h010; bus.len = 11'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ab_busy", {31'b0, bus.busy}, 32'd0);
    check("ab_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("ab_done", {31'b0, bus.done}, 32'd0);
    check("ab_rd_valid2", {31'b0, bus2.rd_valid}, 32'd0);
    repeat (10) @(negedge clk);
    check("ab_count", 32'(q1.size()), 32'd3);
    check("ab_count2", 32'(q2.size()), 32'd2);
    check("ab_no_done", 32'(dn1 - db1), 32'd0);
    check("ab_no_done2", 32'(dn2 - db2), 32'd0);
    @(posedge clk); #1;

    // RD_LAT=2 read of 2 words at 0x010
    read_burst(10'h010, 2, st);
    check("l2_count", 32'(q2.size()), 32'd2);
    check("l2_w0", q2[0], 32'hA0);
    check("l2_w1", q2[1], 32'hA1);
    check("l2_lat", 32'(first2 - st), 32'd2);
    check("l2_donegap", 32'(done2 - last2), 32'd2);
    check("l1_w1", q1[1], 32'hA1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
